// File: rtl/sram_controller_pkg.sv
// Shared types for the SRAM port-0 arbiter: power FSM encodings, arbiter
// states, requester IDs and the SRAM command record.
package sram_controller_pkg;

   localparam logic [1:0] PWR_ACTIVE = 2'b00;
   localparam logic [1:0] PWR_SLEEP  = 2'b01;
   localparam logic [1:0] PWR_WAKEUP = 2'b10;

   typedef enum logic [1:0] {
      ARB_RUN   = 2'b00,
      ARB_DRAIN = 2'b01,
      ARB_HALT  = 2'b10
   } arb_state_t;

   typedef enum logic {
      REQ_HOST  = 1'b0,
      REQ_MAINT = 1'b1
   } req_id_t;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } sram_cmd_t;

endpackage

// File: rtl/sram_controller_arb_rd_pipe.sv
// Read-return tag pipeline: carries the requester ID of each read alongside
// the SRAM latency and steers sram_dout0 to that requester's rdata/rvalid.
module sram_controller_arb_rd_pipe
   import sram_controller_pkg::*;
#(
   parameter int RD_LAT = 1
)
(
   input  logic        hclk,
   input  logic        hreset_n,
   input  logic        i_push,
   input  req_id_t     i_pushId,
   input  logic [31:0] i_dout,
   output logic        o_busyNext,
   output logic        o_hRvalid,
   output logic [31:0] o_hRdata,
   output logic        o_mRvalid,
   output logic [31:0] o_mRdata
);

   logic [RD_LAT:0] r_valid;
   req_id_t         r_id [RD_LAT+1];
   logic            r_hRvalid;
   logic            r_mRvalid;
   logic [31:0]     r_hRdata;
   logic [31:0]     r_mRdata;
   logic            w_exitH;
   logic            w_exitM;

   assign w_exitH    = r_valid[RD_LAT] && (r_id[RD_LAT] == REQ_HOST);
   assign w_exitM    = r_valid[RD_LAT] && (r_id[RD_LAT] == REQ_MAINT);
   // The last stage is being consumed this cycle, so it does not keep the pipe busy.
   assign o_busyNext = i_push | (|r_valid[RD_LAT-1:0]);

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_valid   <= '0;
         for (int i = 0; i <= RD_LAT; i++) r_id[i] <= REQ_HOST;
         r_hRvalid <= 1'b0;
         r_mRvalid <= 1'b0;
         r_hRdata  <= '0;
         r_mRdata  <= '0;
      end else begin
         r_valid <= {r_valid[RD_LAT-1:0], i_push};
         r_id[0] <= i_pushId;
         for (int i = 1; i <= RD_LAT; i++) r_id[i] <= r_id[i-1];
         r_hRvalid <= w_exitH;
         r_mRvalid <= w_exitM;
         if (w_exitH) r_hRdata <= i_dout;
         if (w_exitM) r_mRdata <= i_dout;
      end
   end

   assign o_hRvalid = r_hRvalid;
   assign o_hRdata  = r_hRdata;
   assign o_mRvalid = r_mRvalid;
   assign o_mRdata  = r_mRdata;

endmodule

// File: rtl/sram_controller_port_arb.sv
// Port-0 arbiter/sequencer for the sky130 1RW1R SRAM: host vs maintenance
// grants, registered SRAM command, power drain. Optional: SRAM_ARB_STARVE_GUARD_EN.
module sram_controller_port_arb
   import sram_controller_pkg::*;
#(
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 8
)
(
   input  logic        hclk,
   input  logic        hreset_n,
   input  logic [1:0]  fsm_state,
   input  logic        h_req,
   input  logic        h_we,
   input  logic [7:0]  h_addr,
   input  logic [31:0] h_wdata,
   input  logic [3:0]  h_wmask,
   output logic        h_gnt,
   output logic        h_rvalid,
   output logic [31:0] h_rdata,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [7:0]  m_addr,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_wmask,
   output logic        m_gnt,
   output logic        m_rvalid,
   output logic [31:0] m_rdata,
   output logic        sram_csb0,
   output logic        sram_web0,
   output logic [7:0]  sram_addr0,
   output logic [31:0] sram_din0,
   output logic [3:0]  sram_wmask0,
   input  logic [31:0] sram_dout0,
   output logic        arb_idle,
   output logic [1:0]  arb_state
);

   if (RD_LAT < 1 || RD_LAT > 3 || STARVE_LIMIT < 1) begin : g_badParam
      $error("sram_controller_port_arb: RD_LAT must be 1..3 and STARVE_LIMIT >= 1");
   end

   arb_state_t  r_state;
   logic        r_csb0;
   logic        r_web0;
   logic [7:0]  r_addr;
   logic [31:0] r_din;
   logic [3:0]  r_wmask;
   logic        r_idle;
   logic        w_active;
   logic        w_run;
   logic        w_mForce;
   logic        w_hGnt;
   logic        w_mGnt;
   logic        w_anyGnt;
   logic        w_rdPush;
   logic        w_pipeBusyNext;
   sram_cmd_t   w_cmd;

   assign w_active = (fsm_state == PWR_ACTIVE);
   assign w_run    = (r_state == ARB_RUN);
   assign w_hGnt   = w_run & h_req & ~(w_mForce & m_req);
   assign w_mGnt   = w_run & m_req & (~h_req | w_mForce);
   assign w_anyGnt = w_hGnt | w_mGnt;

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] r_starve;

   assign w_mForce = (r_starve == CW'(STARVE_LIMIT));

   // Counts consecutive denied maintenance cycles; saturates at the limit.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n)            r_starve <= '0;
      else if (!m_req || w_mGnt) r_starve <= '0;
      else if (!w_mForce)        r_starve <= r_starve + CW'(1);
   end
`else
   assign w_mForce = 1'b0;
`endif

   always_comb begin
      w_cmd = '{we: h_we, addr: h_addr, wdata: h_wdata, wmask: h_wmask};
      if (w_mGnt) w_cmd = '{we: m_we, addr: m_addr, wdata: m_wdata, wmask: m_wmask};
   end

   assign w_rdPush = w_anyGnt & ~w_cmd.we;

   // State and the registered SRAM pins advance together so a grant in the
   // last RUN cycle still reaches the macro before DRAIN begins.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_state <= ARB_HALT;
         r_csb0  <= 1'b1;
         r_web0  <= 1'b1;
         r_addr  <= '0;
         r_din   <= '0;
         r_wmask <= '0;
         r_idle  <= 1'b1;
      end else begin
         case (r_state)
            ARB_RUN:   if (!w_active) r_state <= ARB_DRAIN;
            ARB_DRAIN: begin
               if (r_idle)        r_state <= ARB_HALT;
               else if (w_active) r_state <= ARB_RUN;
            end
            default:   if (w_active) r_state <= ARB_RUN;
         endcase
         r_idle <= ~w_anyGnt & ~w_pipeBusyNext;
         if (w_anyGnt) begin
            r_csb0  <= 1'b0;
            r_web0  <= ~w_cmd.we;
            r_addr  <= w_cmd.addr;
            r_din   <= w_cmd.we ? w_cmd.wdata : 32'h0;
            r_wmask <= w_cmd.we ? w_cmd.wmask : 4'h0;
         end else begin
            r_csb0  <= 1'b1;
            r_web0  <= 1'b1;
         end
      end
   end

   sram_controller_arb_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rdPipe (
      .hclk       (hclk),
      .hreset_n   (hreset_n),
      .i_push     (w_rdPush),
      .i_pushId   (w_mGnt ? REQ_MAINT : REQ_HOST),
      .i_dout     (sram_dout0),
      .o_busyNext (w_pipeBusyNext),
      .o_hRvalid  (h_rvalid),
      .o_hRdata   (h_rdata),
      .o_mRvalid  (m_rvalid),
      .o_mRdata   (m_rdata)
   );

   assign h_gnt       = w_hGnt;
   assign m_gnt       = w_mGnt;
   assign sram_csb0   = r_csb0;
   assign sram_web0   = r_web0;
   assign sram_addr0  = r_addr;
   assign sram_din0   = r_din;
   assign sram_wmask0 = r_wmask;
   assign arb_idle    = r_idle;
   assign arb_state   = r_state;

endmodule

// File: tb/tb_sram_controller_port_arb.sv
// Directed bench for sram_controller_port_arb with a behavioural SRAM model
// (RD_LAT=1); follows SRAM_ARB_STARVE_GUARD_EN for the contention pattern.
module tb_sram_controller_port_arb;

   logic        hclk = 1'b0;
   logic        hreset_n = 1'b0;
   logic [1:0]  fsm_state = 2'b00;
   logic        h_req = 1'b0, h_we = 1'b0;
   logic [7:0]  h_addr = '0;
   logic [31:0] h_wdata = '0;
   logic [3:0]  h_wmask = '0;
   logic        h_gnt, h_rvalid;
   logic [31:0] h_rdata;
   logic        m_req = 1'b0, m_we = 1'b0;
   logic [7:0]  m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wmask = '0;
   logic        m_gnt, m_rvalid;
   logic [31:0] m_rdata;
   logic        sram_csb0, sram_web0;
   logic [7:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [3:0]  sram_wmask0;
   logic [31:0] sram_dout0 = '0;
   logic        arb_idle;
   logic [1:0]  arb_state;

   logic [31:0] mem [256];
   int          compared = 0;
   int          mismatched = 0;
   int          rvCount;
   logic        expM;

   sram_controller_port_arb dut (
      .hclk(hclk), .hreset_n(hreset_n), .fsm_state(fsm_state),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_wmask(h_wmask),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
      .sram_din0(sram_din0), .sram_wmask0(sram_wmask0), .sram_dout0(sram_dout0),
      .arb_idle(arb_idle), .arb_state(arb_state)
   );

   always #5 hclk = ~hclk;

   // SRAM macro model: command latched at the clock edge, read data valid the next cycle.
   always @(posedge hclk) begin
      if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] = sram_din0[8*b +: 8];
         end else begin
            sram_dout0 <= mem[sram_addr0];
         end
      end
   end

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic applyStimulus(input logic hReq, input logic hWe, input logic [7:0] hAddr,
                                input logic [31:0] hWdata, input logic [3:0] hWmask,
                                input logic mReq, input logic mWe, input logic [7:0] mAddr,
                                input logic [31:0] mWdata, input logic [3:0] mWmask);
      h_req = hReq; h_we = hWe; h_addr = hAddr; h_wdata = hWdata; h_wmask = hWmask;
      m_req = mReq; m_we = mWe; m_addr = mAddr; m_wdata = mWdata; m_wmask = mWmask;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[1] = 32'hA5A5_A5A5;
      mem[2] = 32'h5A5A_5A5A;

      // Reset and park, with a host write already pending.
      applyStimulus(1, 1, 8'h12, 32'hDEAD_BEEF, 4'hF, 0, 0, 8'h00, 32'h0, 4'h0);
      repeat (2) @(posedge hclk);
      #1;
      checkOutput("rst_csb0", sram_csb0, 1);
      checkOutput("rst_web0", sram_web0, 1);
      checkOutput("rst_addr0", sram_addr0, 0);
      checkOutput("rst_state", arb_state, 2);
      checkOutput("rst_idle", arb_idle, 1);
      checkOutput("rst_hgnt", h_gnt, 0);
      hreset_n = 1'b1;
      #1;
      checkOutput("rel_state_halt", arb_state, 2);
      checkOutput("rel_hgnt_halt", h_gnt, 0);

      // Host write then read of the same address.
      step();
      checkOutput("run_state", arb_state, 0);
      checkOutput("wr_hgnt", h_gnt, 1);
      step();
      applyStimulus(1, 0, 8'h12, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      checkOutput("wr_csb0", sram_csb0, 0);
      checkOutput("wr_web0", sram_web0, 0);
      checkOutput("wr_addr0", sram_addr0, 32'h12);
      checkOutput("wr_din0", sram_din0, 32'hDEAD_BEEF);
      checkOutput("wr_wmask0", sram_wmask0, 4'hF);
      checkOutput("rd_hgnt", h_gnt, 1);
      step();
      applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      checkOutput("rd_csb0", sram_csb0, 0);
      checkOutput("rd_web0", sram_web0, 1);
      checkOutput("rd_din0", sram_din0, 0);
      checkOutput("rd_wmask0", sram_wmask0, 0);
      checkOutput("rd_busy", arb_idle, 0);
      step();
      checkOutput("idle_csb0", sram_csb0, 1);
      checkOutput("idle_addr_hold", sram_addr0, 32'h12);
      checkOutput("rd_rvalid_early", h_rvalid, 0);
      step();
      checkOutput("raw_hrvalid", h_rvalid, 1);
      checkOutput("raw_hrdata", h_rdata, 32'hDEAD_BEEF);
      checkOutput("raw_mrvalid", m_rvalid, 0);
      step();
      checkOutput("raw_hrvalid_pulse", h_rvalid, 0);
      checkOutput("raw_idle", arb_idle, 1);
      checkOutput("raw_hrdata_hold", h_rdata, 32'hDEAD_BEEF);

      // Interleaved host and maintenance reads.
      step();
      applyStimulus(1, 0, 8'h01, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      checkOutput("il_hgnt", h_gnt, 1);
      checkOutput("il_mgnt_none", m_gnt, 0);
      step();
      applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 1, 0, 8'h02, 32'h0, 4'h0);
      checkOutput("il_mgnt", m_gnt, 1);
      step();
      applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      step();
      checkOutput("il_hrvalid", h_rvalid, 1);
      checkOutput("il_hrdata", h_rdata, 32'hA5A5_A5A5);
      checkOutput("il_mrvalid_early", m_rvalid, 0);
      step();
      checkOutput("il_mrvalid", m_rvalid, 1);
      checkOutput("il_mrdata", m_rdata, 32'h5A5A_5A5A);
      checkOutput("il_hrvalid_off", h_rvalid, 0);
      step();

      // Continuous contention between the two requesters.
      step();
      applyStimulus(1, 1, 8'h80, 32'h1111_1111, 4'hF, 1, 1, 8'h81, 32'h2222_2222, 4'hF);
      for (int i = 1; i <= 18; i++) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
         expM = ((i % 9) == 0);
`else
         expM = 1'b0;
`endif
         checkOutput($sformatf("cont_mgnt_%0d", i), m_gnt, expM);
         checkOutput($sformatf("cont_hgnt_%0d", i), h_gnt, !expM);
         step();
      end
      applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      repeat (3) step();

      // Power-down drain around an in-flight read.
      applyStimulus(1, 0, 8'h12, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      checkOutput("dr_hgnt", h_gnt, 1);
      step();
      applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      fsm_state = 2'b01;
      #1;
      checkOutput("dr_state_run", arb_state, 0);
      step();
      applyStimulus(1, 0, 8'h01, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      checkOutput("dr_state_drain", arb_state, 1);
      checkOutput("dr_hgnt_blocked", h_gnt, 0);
      checkOutput("dr_busy", arb_idle, 0);
      step();
      checkOutput("dr_hrvalid", h_rvalid, 1);
      checkOutput("dr_hrdata", h_rdata, 32'hDEAD_BEEF);
      checkOutput("dr_state_drain2", arb_state, 1);
      checkOutput("dr_hgnt_blocked2", h_gnt, 0);
      step();
      checkOutput("dr_state_halt", arb_state, 2);
      checkOutput("dr_idle", arb_idle, 1);
      checkOutput("dr_csb0", sram_csb0, 1);
      checkOutput("dr_hgnt_halt", h_gnt, 0);
      fsm_state = 2'b00;
      step();
      checkOutput("wk_state_run", arb_state, 0);
      checkOutput("wk_hgnt", h_gnt, 1);
      step();
      applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      repeat (2) step();
      checkOutput("wk_hrvalid", h_rvalid, 1);
      checkOutput("wk_hrdata", h_rdata, 32'hA5A5_A5A5);
      step();

      // Reset one cycle after a read grant: the read must never return.
      step();
      applyStimulus(1, 0, 8'h02, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      checkOutput("mr_hgnt", h_gnt, 1);
      step();
      applyStimulus(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0);
      hreset_n = 1'b0;
      #1;
      checkOutput("mr_csb0", sram_csb0, 1);
      checkOutput("mr_web0", sram_web0, 1);
      checkOutput("mr_addr0", sram_addr0, 0);
      checkOutput("mr_state", arb_state, 2);
      checkOutput("mr_idle", arb_idle, 1);
      checkOutput("mr_hrdata", h_rdata, 0);
      checkOutput("mr_mrdata", m_rdata, 0);
      rvCount = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 1) hreset_n = 1'b1;
         #1;
         rvCount += int'(h_rvalid) + int'(m_rvalid);
      end
      checkOutput("mr_no_rvalid", rvCount, 0);
      checkOutput("mr_hrdata_after", h_rdata, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
